// File: rtl/i2s_pkg.sv
// Shared constants, bit-counter type and sample truncation helper for the I2S output stage.
package i2s_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef logic [$clog2(FRAME_BITS)-1:0] bit_cnt_t;

  // Keeps the top sample_width bits of a data_width-bit sample (plain truncation, no rounding).
  function automatic logic [63:0] truncate_sample(input logic [63:0] din,
                                                  input int data_width,
                                                  input int sample_width);
    return din >> (data_width - sample_width);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_output_stage.sv
// Truncates mono samples, buffers them and serializes each one onto both I2S slots.
module i2s_output_stage
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int BCLK_DIV     = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic [DATA_WIDTH-1:0]         audio_in,
  input  logic                          clear_status,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int POS_W  = $clog2(SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCLK_DIV/2 - 1);
  localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]        div_cnt;
  bit_cnt_t                bit_cnt;
  bit_cnt_t                next_bit;
  logic [SAMPLE_WIDTH-1:0] held;
  logic [SAMPLE_WIDTH-1:0] sample_trunc;
  logic [SAMPLE_WIDTH-1:0] fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    bclk_fall;
  logic                    frame_start;
  logic                    pop;
  logic                    overflow_evt;
  logic                    underrun_evt;
  logic [POS_W-1:0]        pos;
  logic [POS_W-1:0]        bit_idx;
  logic [SLOT_BITS-1:0]    held_pad;
  logic                    next_sdata;

  assign sample_trunc = SAMPLE_WIDTH'(truncate_sample(64'(audio_in), DATA_WIDTH, SAMPLE_WIDTH));

  assign bclk_fall    = (div_cnt == DIV_FALL);
  assign next_bit     = bit_cnt + bit_cnt_t'(1);
  assign frame_start  = bclk_fall && (next_bit == '0);
  assign pop          = frame_start && !fifo_empty;
  assign overflow_evt = sample_valid && fifo_full && !pop;
  assign underrun_evt = frame_start && fifo_empty;

  sample_fifo #(
    .DATA_WIDTH (SAMPLE_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (sample_valid),
    .din   (sample_trunc),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Slot position 0 carries the one-bit I2S delay; MSB goes out at position 1.
  assign pos      = next_bit[POS_W-1:0];
  assign bit_idx  = POS_W'(SAMPLE_WIDTH) - pos;
  assign held_pad = {{(SLOT_BITS-SAMPLE_WIDTH){1'b0}}, held};

  always_comb begin
    next_sdata = 1'b0;
    if (pos != '0 && pos <= POS_W'(SAMPLE_WIDTH)) next_sdata = held_pad[bit_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      held      <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      div_cnt <= bclk_fall ? '0 : div_cnt + 1'b1;
      if (div_cnt == DIV_RISE) i2s_bclk <= 1'b1;
      if (bclk_fall) begin
        i2s_bclk  <= 1'b0;
        bit_cnt   <= next_bit;
        i2s_lrclk <= next_bit[POS_W];
        i2s_sdata <= next_sdata;
        if (pop) held <= fifo_dout;
      end
      if (overflow_evt)      overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;
      if (underrun_evt)      underrun <= 1'b1;
      else if (clear_status) underrun <= 1'b0;
    end
  end

endmodule
